// File: rtl/axis_tp_gen_mc.sv
// AXI4-Stream multi-pattern video test source (counter, bars, checkerboard, solid).
// Define AXIS_TP_GEN_BLANK_EN to insert idle blanking cycles after lines and frames.
module axis_tp_gen_mc #(
    parameter int COMP_W  = 8,
    parameter int PIX_CH  = 3,
    parameter int DIM_W   = 11,
    parameter int SQ_LOG2 = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tp_enable_i,
    input  logic [1:0]               tp_type_i,
    input  logic [DIM_W-1:0]         tp_width_i,
    input  logic [DIM_W-1:0]         tp_height_i,
    input  logic [PIX_CH*COMP_W-1:0] tp_color_i,
    input  logic [7:0]               tp_hblank_i,
    input  logic [7:0]               tp_vblank_i,
    output logic [PIX_CH*COMP_W-1:0] m_axis_tdata_o,
    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     m_axis_tuser_o,
    output logic                     m_axis_tlast_o,
    output logic                     busy_o,
    output logic [7:0]               frame_cnt_o,
    output logic                     cfg_err_o
);

    localparam int DW = PIX_CH * COMP_W;

`ifdef AXIS_TP_GEN_BLANK_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;
`else
    typedef enum logic {IDLE, ACTIVE} state_t;
`endif

    state_t           state, state_n;
    logic [DIM_W-1:0] x, x_n, y, y_n;
    logic [7:0]       fc_n;
    logic [2:0]       bar, bar_n;
    logic [DIM_W-1:0] bar_cnt, bar_cnt_n, bar_w, bar_w_n;
    logic [1:0]       cfg_type, type_n;
    logic [DIM_W-1:0] cfg_w, w_n, cfg_h, h_n;
    logic [DW-1:0]    cfg_color, color_n;
    logic             err_n;
    logic             last_px, last_ln;

`ifdef AXIS_TP_GEN_BLANK_EN
    logic [7:0]       cfg_hb, hb_n, cfg_vb, vb_n;
    logic [8:0]       blk_cnt, blk_n, blen;
    logic             blk_frame, blk_frame_n;
`else
    logic             unused_blank;
    assign unused_blank = ^{tp_hblank_i, tp_vblank_i};
`endif

    function automatic logic [DW-1:0] pix(
        input logic [1:0]       t,
        input logic [DIM_W-1:0] px,
        input logic [DIM_W-1:0] py,
        input logic [7:0]       f,
        input logic [2:0]       b,
        input logic [DW-1:0]    col
    );
        logic [DW-1:0] d;
        logic [3:0]    code;
        d = '0;
        case (b)
            3'd0:    code = 4'hF;
            3'd1:    code = 4'hE;
            3'd2:    code = 4'hB;
            3'd3:    code = 4'hA;
            3'd4:    code = 4'hD;
            3'd5:    code = 4'hC;
            3'd6:    code = 4'h9;
            default: code = 4'h8;
        endcase
        case (t)
            2'd0: begin
                for (int unsigned k = 0; k < PIX_CH; k++) begin
                    case (k)
                        0:       d[k*COMP_W +: COMP_W] = COMP_W'(px);
                        1:       d[k*COMP_W +: COMP_W] = COMP_W'(py);
                        2:       d[k*COMP_W +: COMP_W] = COMP_W'(f);
                        default: d[k*COMP_W +: COMP_W] = '0;
                    endcase
                end
            end
            // bit 3 of code is constant 1 so component 3 is always full scale
            2'd1: begin
                for (int unsigned k = 0; k < PIX_CH; k++)
                    d[k*COMP_W +: COMP_W] = {COMP_W{code[k]}};
            end
            2'd2:    d = (px[SQ_LOG2] ^ py[SQ_LOG2]) ? col : '0;
            default: d = col;
        endcase
        return d;
    endfunction

    always_comb begin
        state_n   = state;
        x_n       = x;
        y_n       = y;
        fc_n      = frame_cnt_o;
        bar_n     = bar;
        bar_cnt_n = bar_cnt;
        bar_w_n   = bar_w;
        type_n    = cfg_type;
        w_n       = cfg_w;
        h_n       = cfg_h;
        color_n   = cfg_color;
        err_n     = cfg_err_o;
        last_px   = (x == cfg_w - DIM_W'(1));
        last_ln   = (y == cfg_h - DIM_W'(1));
`ifdef AXIS_TP_GEN_BLANK_EN
        hb_n        = cfg_hb;
        vb_n        = cfg_vb;
        blk_n       = blk_cnt;
        blk_frame_n = blk_frame;
        blen        = last_ln ? ({1'b0, cfg_hb} + {1'b0, cfg_vb}) : {1'b0, cfg_hb};
`endif
        case (state)
            IDLE: begin
                if (tp_enable_i) begin
                    if (tp_width_i == '0 || tp_height_i == '0) begin
                        err_n = 1'b1;
                    end else begin
                        state_n   = ACTIVE;
                        type_n    = tp_type_i;
                        w_n       = tp_width_i;
                        h_n       = tp_height_i;
                        color_n   = tp_color_i;
                        x_n       = '0;
                        y_n       = '0;
                        bar_n     = '0;
                        bar_cnt_n = '0;
                        bar_w_n   = ((tp_width_i >> 3) == '0) ? DIM_W'(1) : (tp_width_i >> 3);
`ifdef AXIS_TP_GEN_BLANK_EN
                        hb_n      = tp_hblank_i;
                        vb_n      = tp_vblank_i;
`endif
                    end
                end
            end
            ACTIVE: begin
                if (m_axis_tready_i) begin
                    if (last_px) begin
                        x_n       = '0;
                        bar_n     = '0;
                        bar_cnt_n = '0;
                        if (last_ln) begin
                            y_n  = '0;
                            fc_n = frame_cnt_o + 8'd1;
                        end else begin
                            y_n  = y + DIM_W'(1);
                        end
`ifdef AXIS_TP_GEN_BLANK_EN
                        if (blen != '0) begin
                            state_n     = BLANK;
                            blk_n       = blen - 9'd1;
                            blk_frame_n = last_ln;
                        end else if (last_ln && !tp_enable_i) begin
                            state_n = IDLE;
                        end
`else
                        if (last_ln && !tp_enable_i)
                            state_n = IDLE;
`endif
                    end else begin
                        x_n = x + DIM_W'(1);
                        // remainder pixels stay in bar 7, so it never advances past 7
                        if (bar != 3'd7 && bar_cnt == bar_w - DIM_W'(1)) begin
                            bar_n     = bar + 3'd1;
                            bar_cnt_n = '0;
                        end else begin
                            bar_cnt_n = bar_cnt + DIM_W'(1);
                        end
                    end
                end
            end
`ifdef AXIS_TP_GEN_BLANK_EN
            BLANK: begin
                if (blk_cnt == '0)
                    state_n = (blk_frame && !tp_enable_i) ? IDLE : ACTIVE;
                else
                    blk_n = blk_cnt - 9'd1;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            x               <= '0;
            y               <= '0;
            bar             <= '0;
            bar_cnt         <= '0;
            bar_w           <= '0;
            cfg_type        <= '0;
            cfg_w           <= '0;
            cfg_h           <= '0;
            cfg_color       <= '0;
            frame_cnt_o     <= '0;
            cfg_err_o       <= 1'b0;
            busy_o          <= 1'b0;
            m_axis_tvalid_o <= 1'b0;
            m_axis_tuser_o  <= 1'b0;
            m_axis_tlast_o  <= 1'b0;
            m_axis_tdata_o  <= '0;
`ifdef AXIS_TP_GEN_BLANK_EN
            cfg_hb          <= '0;
            cfg_vb          <= '0;
            blk_cnt         <= '0;
            blk_frame       <= 1'b0;
`endif
        end else begin
            state           <= state_n;
            x               <= x_n;
            y               <= y_n;
            bar             <= bar_n;
            bar_cnt         <= bar_cnt_n;
            bar_w           <= bar_w_n;
            cfg_type        <= type_n;
            cfg_w           <= w_n;
            cfg_h           <= h_n;
            cfg_color       <= color_n;
            frame_cnt_o     <= fc_n;
            cfg_err_o       <= err_n;
            busy_o          <= (state_n != IDLE);
            m_axis_tvalid_o <= (state_n == ACTIVE);
            m_axis_tuser_o  <= (state_n == ACTIVE) && (x_n == '0) && (y_n == '0);
            m_axis_tlast_o  <= (state_n == ACTIVE) && (x_n == w_n - DIM_W'(1));
            m_axis_tdata_o  <= (state_n == ACTIVE) ?
                               pix(type_n, x_n, y_n, fc_n, bar_n, color_n) : '0;
`ifdef AXIS_TP_GEN_BLANK_EN
            cfg_hb          <= hb_n;
            cfg_vb          <= vb_n;
            blk_cnt         <= blk_n;
            blk_frame       <= blk_frame_n;
`endif
        end
    end

endmodule

// File: tb/tb_axis_tp_gen_mc.sv
// Scoreboard bench for axis_tp_gen_mc: stimulus pushes expected beats, a monitor pops them.
module tb_axis_tp_gen_mc;

    logic        clk, rst, en, tready;
    logic [1:0]  typ;
    logic [10:0] w, h;
    logic [23:0] color, tdata;
    logic [7:0]  hb, vb, fc;
    logic        tvalid, tuser, tlast, busy, cfg_err;

    axis_tp_gen_mc #(.COMP_W(8), .PIX_CH(3), .DIM_W(11), .SQ_LOG2(1)) dut (
        .clk_i(clk), .rst_i(rst), .tp_enable_i(en), .tp_type_i(typ),
        .tp_width_i(w), .tp_height_i(h), .tp_color_i(color),
        .tp_hblank_i(hb), .tp_vblank_i(vb),
        .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
        .m_axis_tuser_o(tuser), .m_axis_tlast_o(tlast),
        .busy_o(busy), .frame_cnt_o(fc), .cfg_err_o(cfg_err)
    );

    typedef struct packed {
        logic [23:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    acc = 0;
    int    stall_last = 0;
    int    mode = 0;
    bit    stall_done = 0;
    int    fc_model = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input int t, input int x, input int y,
                                              input int f, input int wd, input logic [23:0] col);
        int codes[8] = '{7, 6, 3, 2, 5, 4, 1, 0};
        int bw, b;
        logic [23:0] d;
        d = '0;
        case (t)
            0: d = {8'(f), 8'(y), 8'(x)};
            1: begin
                bw = (wd / 8 == 0) ? 1 : wd / 8;
                b  = x / bw;
                if (b > 7) b = 7;
                for (int k = 0; k < 3; k++)
                    if (((codes[b] >> k) & 1) == 1) d[k*8 +: 8] = 8'hFF;
            end
            2: d = ((((x >> 1) ^ (y >> 1)) & 1) == 1) ? col : 24'h0;
            default: d = col;
        endcase
        return d;
    endfunction

    task automatic push_frames(input int t, input int wd, input int ht, input logic [23:0] col,
                               input int f0, input int nf);
        for (int f = 0; f < nf; f++)
            for (int yy = 0; yy < ht; yy++)
                for (int xx = 0; xx < wd; xx++)
                    q.push_back('{model_pix(t, xx, yy, (f0 + f) & 255, wd, col),
                                  (xx == 0 && yy == 0), (xx == wd - 1)});
    endtask

    // tready driver: steady, random, or a single 5-cycle stall on the first tlast beat
    initial begin
        tready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (mode == 1) begin
                tready = 1'($urandom_range(0, 1));
            end else if (mode == 2 && !stall_done && tvalid && tlast) begin
                tready = 0;
                repeat (5) @(posedge clk);
                #1;
                tready = 1;
                stall_done = 1;
            end else begin
                tready = 1;
            end
        end
    end

    // monitor
    initial begin
        logic [25:0] prev;
        bit          prev_stall;
        beat_t       b;
        prev = '0;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", {38'h0, tdata, tuser, tlast}, {38'h0, prev});
                if (mode == 2 && tvalid && !tready && tlast)
                    stall_last++;
                if (tvalid && tready) begin
                    acc++;
                    if (q.size() == 0) begin
                        chk("extra_beat", 64'd1, 64'd0);
                    end else begin
                        b = q.pop_front();
                        chk("tdata", {40'h0, tdata}, {40'h0, b.d});
                        chk("tuser", {63'h0, tuser}, {63'h0, b.u});
                        chk("tlast", {63'h0, tlast}, {63'h0, b.l});
                    end
                end
                prev = {tdata, tuser, tlast};
                prev_stall = tvalid && !tready;
            end
        end
    end

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("idle_timeout", {63'h0, busy}, 64'd0);
    endtask

    task automatic run_one(input string name, input int t, input int wd, input int ht,
                           input logic [23:0] col, input int exp_cycles);
        int cnt;
        typ = 2'(t); w = 11'(wd); h = 11'(ht); color = col;
        push_frames(t, wd, ht, col, fc_model, 1);
        en = 1;
        @(posedge clk);
        #1;
        en = 0;
        wait_idle(cnt);
        if (exp_cycles >= 0)
            chk({name, "_cycles"}, 64'(cnt), 64'(exp_cycles));
        fc_model = (fc_model + 1) & 255;
        chk({name, "_frame_cnt"}, {56'h0, fc}, 64'(fc_model));
        chk({name, "_drained"}, 64'(q.size()), 64'd0);
        chk({name, "_tvalid_off"}, {63'h0, tvalid}, 64'd0);
    endtask

    initial begin
        int cnt, a0, blank_extra;
        rst = 1; en = 0; typ = 0; w = 4; h = 2; color = 0; hb = 0; vb = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", {63'h0, tvalid}, 64'd0);
        chk("rst_tuser", {63'h0, tuser}, 64'd0);
        chk("rst_tlast", {63'h0, tlast}, 64'd0);
        chk("rst_tdata", {40'h0, tdata}, 64'd0);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_fc", {56'h0, fc}, 64'd0);
        chk("rst_cfg_err", {63'h0, cfg_err}, 64'd0);
        rst = 0;
        @(posedge clk);
        #1;

        run_one("counter4x2", 0, 4, 2, 24'h0, 8);

`ifdef AXIS_TP_GEN_BLANK_EN
        blank_extra = 3 + 3 + 5;
`else
        blank_extra = 0;
`endif
        hb = 3; vb = 5;
        run_one("blank4x2", 0, 4, 2, 24'h0, 8 + blank_extra);
        hb = 0; vb = 0;

        mode = 1;
        run_one("bars16x4_rand", 1, 16, 4, 24'h0, -1);
        mode = 0;
        run_one("bars19x2", 1, 19, 2, 24'h0, 38);

        mode = 2; stall_done = 0; stall_last = 0;
        run_one("stall_tlast", 0, 4, 2, 24'h0, 13);
        chk("stall_tlast_cycles", 64'(stall_last), 64'd5);
        mode = 0;

        run_one("checker8x4", 2, 8, 4, 24'hFF00FF, 32);
        run_one("solid1x1", 3, 1, 1, 24'h123456, 1);

        // three 8x8 frames; enable dropped inside the third; config changes ignored
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        fc_model = 0;
        typ = 0; w = 8; h = 8;
        push_frames(0, 8, 8, 24'h0, 0, 3);
        a0 = acc;
        en = 1;
        @(posedge clk);
        #1;
        typ = 3; w = 5; h = 3;
        cnt = 0;
        while (acc - a0 < 148 && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("mid_frame_reach", 64'(acc - a0 >= 148), 64'd1);
        en = 0;
        wait_idle(cnt);
        chk("multi_frame_cnt", {56'h0, fc}, 64'd3);
        chk("multi_drained", 64'(q.size()), 64'd0);
        chk("multi_beats", 64'(acc - a0), 64'd192);
        chk("multi_tvalid_off", {63'h0, tvalid}, 64'd0);
        fc_model = 3;

        w = 0; h = 4; en = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("zero_w_cfg_err", {63'h0, cfg_err}, 64'd1);
        chk("zero_w_tvalid", {63'h0, tvalid}, 64'd0);
        chk("zero_w_busy", {63'h0, busy}, 64'd0);
        en = 0;

        // reset in mid-frame aborts at once and clears sticky error
        typ = 0; w = 8; h = 8;
        push_frames(0, 8, 8, 24'h0, fc_model, 1);
        a0 = acc;
        en = 1;
        @(posedge clk);
        #1;
        en = 0;
        cnt = 0;
        while (acc - a0 < 10 && cnt < 5000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        rst = 1;
        @(posedge clk);
        #1;
        q.delete();
        chk("abort_tvalid", {63'h0, tvalid}, 64'd0);
        chk("abort_busy", {63'h0, busy}, 64'd0);
        chk("abort_fc", {56'h0, fc}, 64'd0);
        chk("abort_cfg_err", {63'h0, cfg_err}, 64'd0);
        rst = 0;
        @(posedge clk);
        #1;
        chk("post_abort_idle", {63'h0, tvalid}, 64'd0);
        fc_model = 0;
        run_one("after_abort2x2", 0, 2, 2, 24'h0, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
